// File: rtl/pn_pkg.sv
// Shared definitions for the Polish Notation token interface: mode/operator
// codes, the token format and default buffer depths.
package pn_pkg;
  localparam int PN_MAX_TOK = 12;
  localparam int PN_MAX_RES = 4;
  localparam int PN_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    PREFIX_SORT_DESC = 2'd0,
    POSTFIX_SORT_ASC = 2'd1,
    PREFIX_EXPR      = 2'd2,
    POSTFIX_EXPR     = 2'd3
  } pn_mode_e;

  typedef enum logic [2:0] {
    OP_ADD     = 3'd0,
    OP_SUB     = 3'd1,
    OP_MUL     = 3'd2,
    OP_ABS_SUM = 3'd3
  } pn_op_e;

  typedef struct packed {
    logic       op;
    logic [2:0] val;
  } pn_tok_t;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_CAPT} tx_state_e;
endpackage

// File: rtl/pn_res_capture.sv
// Result capture register file: appends beats until full, drops the rest,
// and exposes one slot through a combinational read mux.
module pn_res_capture import pn_pkg::*; #(
  parameter int MAX_RES = PN_MAX_RES,
  parameter int CW      = 3,
  parameter int IW      = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic               i_wr,
  input  logic signed [31:0] i_data,
  input  logic [IW-1:0]      i_idx,
  output logic [CW-1:0]      o_cnt,
  output logic signed [31:0] o_data
);
  logic signed [31:0] r_slot [MAX_RES];
  logic [CW-1:0]      r_cnt;
  logic               w_room;

  assign w_room = (r_cnt < CW'(MAX_RES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      for (int i = 0; i < MAX_RES; i++) r_slot[i] <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_wr && w_room) begin
      for (int i = 0; i < MAX_RES; i++)
        if (r_cnt == CW'(i)) r_slot[i] <= i_data;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_data = (int'(i_idx) < MAX_RES) ? r_slot[i_idx] : '0;
endmodule

// File: rtl/pn_stim_tx.sv
// PN interface initiator: buffers host-loaded tokens, streams them to the
// evaluator one per cycle, then collects the evaluator's result burst.
module pn_stim_tx import pn_pkg::*; #(
  parameter int MAX_TOK = PN_MAX_TOK,
  parameter int MAX_RES = PN_MAX_RES,
  parameter int TIMEOUT = PN_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic               cfg_op,
  input  logic [2:0]         cfg_val,
  input  logic               cfg_clr,
  output logic               cfg_full,
  input  logic               start,
  input  logic [1:0]         start_mode,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [2:0]         res_cnt,
  input  logic [1:0]         res_idx,
  output logic signed [31:0] res_data,
  output logic               pn_in_valid,
  output logic [1:0]         pn_mode,
  output logic               pn_operator,
  output logic [2:0]         pn_in,
  input  logic               pn_out_valid,
  input  logic signed [31:0] pn_out
);
  localparam int TCW = $clog2(MAX_TOK + 1);
  localparam int TW  = ($clog2(TIMEOUT) > 10) ? $clog2(TIMEOUT) : 10;

  tx_state_e     r_state;
  pn_tok_t       r_buf [MAX_TOK];
  logic [TCW-1:0] r_tok_cnt, r_idx;
  logic [TW-1:0] r_wcnt;
  logic          r_done, r_timeout;
  logic          r_vld, r_op;
  logic [2:0]    r_val;
  logic [1:0]    r_mode;
  logic [TW-1:0] w_wcnt_nxt;
  logic          w_cap_wr, w_cap_clr;

  assign w_wcnt_nxt = r_wcnt + TW'(1);
  assign w_cap_wr   = ((r_state == ST_WAIT) || (r_state == ST_CAPT)) && pn_out_valid;
  assign w_cap_clr  = (r_state == ST_IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_tok_cnt <= '0;
      r_idx     <= '0;
      r_wcnt    <= '0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
      r_vld     <= 1'b0;
      r_op      <= 1'b0;
      r_val     <= '0;
      r_mode    <= '0;
      for (int i = 0; i < MAX_TOK; i++) r_buf[i] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_timeout <= 1'b0;
            r_idx     <= TCW'(1);
            if (r_tok_cnt != '0) begin
              // first token goes out on the cycle right after start
              r_state <= ST_SEND;
              r_vld   <= 1'b1;
              r_op    <= r_buf[0].op;
              r_val   <= r_buf[0].val;
              r_mode  <= start_mode;
            end else begin
              r_done <= 1'b1;
            end
          end else if (cfg_clr) begin
            r_tok_cnt <= '0;
          end else if (cfg_we && (r_tok_cnt < TCW'(MAX_TOK))) begin
            r_buf[r_tok_cnt] <= '{op: cfg_op, val: cfg_val};
            r_tok_cnt        <= r_tok_cnt + TCW'(1);
          end
        end
        ST_SEND: begin
          r_mode <= '0;
          if (r_idx < r_tok_cnt) begin
            r_vld <= 1'b1;
            r_op  <= r_buf[r_idx].op;
            r_val <= r_buf[r_idx].val;
            r_idx <= r_idx + TCW'(1);
          end else begin
            r_vld   <= 1'b0;
            r_op    <= 1'b0;
            r_val   <= '0;
            r_wcnt  <= '0;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_wcnt <= w_wcnt_nxt;
          // done shows as the counter reaches TIMEOUT-1: TIMEOUT cycles after the last token
          if (pn_out_valid) begin
            r_state <= ST_CAPT;
          end else if (w_wcnt_nxt == TW'(TIMEOUT - 1)) begin
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        ST_CAPT: begin
          if (!pn_out_valid) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  pn_res_capture #(.MAX_RES(MAX_RES), .CW(3), .IW(2)) u_cap (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_cap_clr),
    .i_wr   (w_cap_wr),
    .i_data (pn_out),
    .i_idx  (res_idx),
    .o_cnt  (res_cnt),
    .o_data (res_data)
  );

  assign cfg_full    = (r_tok_cnt == TCW'(MAX_TOK));
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign pn_in_valid = r_vld;
  assign pn_operator = r_op;
  assign pn_in       = r_val;
  assign pn_mode     = r_mode;
endmodule

// File: tb/tb_pn_stim_tx.sv
// Randomized bench for pn_stim_tx with a queue-based model of the token
// buffer and a scheduled evaluator that answers with chosen result bursts.
module tb_pn_stim_tx;
  localparam int TO   = 1024;
  localparam int MTOK = 12;
  localparam int MRES = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cfg_we = 0, cfg_op = 0, cfg_clr = 0, start = 0;
  logic [2:0]  cfg_val = '0;
  logic [1:0]  start_mode = '0, res_idx = '0;
  logic        pn_out_valid = 0;
  logic signed [31:0] pn_out = '0;
  logic        cfg_full, busy, done, timeout, pn_in_valid, pn_operator;
  logic [2:0]  res_cnt, pn_in;
  logic [1:0]  pn_mode;
  logic signed [31:0] res_data;

  int n_chk = 0, n_bad = 0;
  bit [3:0] mq[$];
  logic [31:0] rv[8];

  always #5 clk = ~clk;

  pn_stim_tx dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_op(cfg_op), .cfg_val(cfg_val),
    .cfg_clr(cfg_clr), .cfg_full(cfg_full), .start(start), .start_mode(start_mode),
    .busy(busy), .done(done), .timeout(timeout), .res_cnt(res_cnt), .res_idx(res_idx),
    .res_data(res_data), .pn_in_valid(pn_in_valid), .pn_mode(pn_mode),
    .pn_operator(pn_operator), .pn_in(pn_in), .pn_out_valid(pn_out_valid), .pn_out(pn_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic load(input bit op, input logic [2:0] val);
    @(negedge clk);
    cfg_we = 1; cfg_op = op; cfg_val = val;
    @(negedge clk);
    cfg_we = 0;
    if (mq.size() < MTOK) mq.push_back({op, val});
    chk("full", cfg_full, mq.size() == MTOK);
  endtask

  task automatic clr(input bit with_we);
    @(negedge clk);
    cfg_clr = 1; cfg_we = with_we; cfg_op = 0; cfg_val = 3'd5;
    @(negedge clk);
    cfg_clr = 0; cfg_we = 0;
    mq.delete();
    chk("clr_full", cfg_full, 0);
  endtask

  // One transaction; relative cycle 1 is the first cycle after start is sampled.
  task automatic run_txn(input logic [1:0] mode, input int nres, input int lat, input bit noise);
    bit [3:0] eq[$];
    int n, exp_done, ndone, ncap, j;
    eq = mq;
    n = eq.size();
    ndone = 0;
    exp_done = (n == 0) ? 1 : (nres == 0) ? n + TO : n + lat + nres + 1;
    ncap = (n == 0) ? 0 : (nres > MRES) ? MRES : nres;
    @(negedge clk);
    start = 1; start_mode = mode;
    if (noise) begin cfg_we = 1; cfg_clr = 1'($urandom); cfg_val = 3'($urandom); end
    for (int c = 1; c <= exp_done + 3; c++) begin
      @(negedge clk);
      if (c <= n) begin
        chk("tok_vld", pn_in_valid, 1);
        chk("tok_op", pn_operator, eq[c-1][3]);
        chk("tok_val", pn_in, eq[c-1][2:0]);
        chk("tok_mode", pn_mode, (c == 1) ? mode : 2'd0);
      end else if (c == n + 1 && n > 0) begin
        chk("bus_idle", {pn_in_valid, pn_operator, pn_in, pn_mode}, 0);
      end else if (c > n) begin
        chk("no_tok", pn_in_valid, 0);
      end
      chk("busy", busy, (n > 0) && (c < exp_done));
      if (done) begin
        ndone++;
        chk("done_cyc", c, exp_done);
      end
      start = 0; start_mode = 2'($urandom);
      cfg_we  = noise && (c <= n) && 1'($urandom);
      cfg_clr = noise && (c <= n) && 1'($urandom);
      cfg_val = 3'($urandom);
      j = c - (n + lat);
      if (n > 0 && j >= 0 && j < nres) begin
        pn_out_valid = 1; pn_out = rv[j];
      end else if (noise && c <= n) begin
        pn_out_valid = 1; pn_out = $urandom;
      end else begin
        pn_out_valid = 0; pn_out = $urandom;
      end
    end
    pn_out_valid = 0; cfg_we = 0; cfg_clr = 0;
    chk("done_once", ndone, 1);
    chk("timeout", timeout, (n > 0) && (nres == 0));
    chk("res_cnt", res_cnt, ncap);
    for (int i = 0; i < ncap; i++) begin
      res_idx = 2'(i);
      #1 chk("res_data", res_data, rv[i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_outs", {cfg_full, busy, done, timeout, pn_in_valid, pn_operator, pn_in, pn_mode}, 0);
    chk("rst_cnt", res_cnt, 0);
    chk("rst_data", res_data, 0);
    @(negedge clk); rst_n = 1;

    // 3 4 + in postfix-sort mode -> 7
    load(0, 3); load(0, 4); load(1, 0);
    rv[0] = 3 + 4;
    run_txn(2'd1, 1, 3, 0);

    // 2 3 + 4 * -> 20
    clr(0);
    load(0, 2); load(0, 3); load(1, 0); load(0, 4); load(1, 2);
    rv[0] = (2 + 3) * 4;
    run_txn(2'd3, 1, 5, 1);

    // * 2 3 + 1 1 -> two results back to back
    clr(0);
    load(1, 2); load(0, 2); load(0, 3); load(1, 0); load(0, 1); load(0, 1);
    rv[0] = 2 * 3; rv[1] = 1 + 1;
    run_txn(2'd0, 2, 1, 0);

    // silent evaluator, then a reply on the last accepted cycle
    clr(0);
    load(0, 5);
    run_txn(2'd2, 0, 1, 0);
    rv[0] = -32'sd9;
    run_txn(2'd2, 1, TO - 1, 0);

    // overfill, then empty start and clear-wins
    clr(0);
    for (int i = 0; i < 13; i++) load(1'($urandom), 3'(i));
    rv[0] = 32'h8000_0001;
    run_txn(2'd2, 1, 2, 1);
    clr(0);
    run_txn(2'd0, 0, 1, 0);
    load(0, 1);
    clr(1);
    run_txn(2'd1, 3, 1, 0);

    // reset during token 5 of 12
    for (int i = 0; i < MTOK; i++) load(0, 3'(i));
    @(negedge clk); start = 1; start_mode = 2'd2;
    @(negedge clk); start = 0;
    repeat (4) @(negedge clk);
    chk("rst_tok5", {pn_in_valid, pn_in}, {1'b1, 3'd4});
    rst_n = 0;
    #1;
    chk("rst_vld", pn_in_valid, 0);
    chk("rst_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_nodone", done, 0);
    end
    rst_n = 1;
    mq.delete();
    chk("rst_full", cfg_full, 0);
    run_txn(2'd1, 2, 1, 0);
    load(0, 7); load(0, 6); load(1, 1);
    for (int i = 0; i < 6; i++) rv[i] = $urandom;
    run_txn(2'd3, 6, 2, 0);

    // randomized transactions
    for (int r = 0; r < 20; r++) begin
      int nl, nr;
      if ($urandom_range(0, 1) == 0) clr($urandom_range(0, 3) == 0);
      nl = $urandom_range(0, 8);
      for (int i = 0; i < nl; i++) load(1'($urandom), 3'($urandom));
      nr = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
      for (int i = 0; i < 8; i++) rv[i] = $urandom;
      run_txn(2'($urandom), nr, $urandom_range(1, 30), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
